ss_ddr_port: RTL and testbench

Responder side of the savestate DDR toggle handshake. Accepts single 64-bit read/write requests from the savestate engine (`ddr_req` toggles, `ddr_ack` follows) and executes them on the MiSTer DDRAM Avalon port. A one-line write-through read cache lets repeated reads of the same 8-byte word complete without a DDR access. Sits between the savestate controller and the DDRAM arbiter in the SNES top level.

---
 rtl/ss_ddr_pkg.sv | 29 ++
 rtl/ss_ddr_port.sv | 151 +++++++++++++++
 tb/tb_ss_ddr_port.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ss_ddr_pkg.sv
// Shared types and widths for the savestate DDR responder port.
package ss_ddr_pkg;

    localparam int unsigned SS_WADDR_W = 19;
    localparam int unsigned DDR_ADDR_W = 29;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned BE_W       = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RDWAIT
    } state_e;

    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int unsigned i = 0; i < BE_W; i++) begin
            if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ss_ddr_port.sv
// Savestate DDR toggle-handshake responder driving the DDRAM Avalon port,
// with a single-line write-through read cache.
module ss_ddr_port
    import ss_ddr_pkg::*;
#(
    parameter logic [9:0] ADDR_HI = 10'h0E0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ddr_req,
    output logic                  ddr_ack,
    input  logic [SS_WADDR_W-1:0] ddr_addr,
    input  logic                  ddr_we,
    input  logic [BE_W-1:0]       ddr_be,
    input  logic [DATA_W-1:0]     ddr_do,
    output logic [DATA_W-1:0]     ddr_di,
    input  logic                  cache_inv,
    input  logic                  DDRAM_BUSY,
    output logic [7:0]            DDRAM_BURSTCNT,
    output logic [DDR_ADDR_W-1:0] DDRAM_ADDR,
    output logic                  DDRAM_RD,
    output logic                  DDRAM_WE,
    output logic [DATA_W-1:0]     DDRAM_DIN,
    output logic [BE_W-1:0]       DDRAM_BE,
    input  logic [DATA_W-1:0]     DDRAM_DOUT,
    input  logic                  DDRAM_DOUT_READY
);

    state_e                  state_q, state_d;
    logic                    ack_q, ack_d;
    logic [DATA_W-1:0]       di_q, di_d;
    logic                    rd_q, rd_d;
    logic                    we_q, we_d;
    logic [DDR_ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]       din_q, din_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic                    valid_q, valid_d;
    logic [SS_WADDR_W-1:0]   tag_q, tag_d;
    logic [DATA_W-1:0]       line_q, line_d;

    logic pending;
    logic tag_match;
    logic hit;

    assign pending   = (ddr_req != ack_q);
    assign tag_match = valid_q && (tag_q == ddr_addr);
    // An invalidate in the same cycle as the lookup forces a miss.
    assign hit       = tag_match && !cache_inv;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        di_d    = di_q;
        rd_d    = rd_q;
        we_d    = we_q;
        addr_d  = addr_q;
        din_d   = din_q;
        be_d    = be_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        line_d  = line_q;

        if (cache_inv) valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pending) begin
                    if (ddr_we || !hit) begin
                        addr_d = {ADDR_HI, ddr_addr};
                        din_d  = ddr_do;
                        be_d   = ddr_be;
                    end
                    if (ddr_we) begin
                        we_d    = 1'b1;
                        state_d = WRITE;
                        if (tag_match) line_d = be_merge(line_q, ddr_do, ddr_be);
                    end else if (hit) begin
                        di_d  = line_q;
                        ack_d = ~ack_q;
                    end else begin
                        rd_d    = 1'b1;
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (!DDRAM_BUSY) begin
                    we_d    = 1'b0;
                    ack_d   = ~ack_q;
                    state_d = IDLE;
                end
            end
            READ: begin
                if (!DDRAM_BUSY) begin
                    rd_d    = 1'b0;
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                // Fill wins over a coincident invalidate: the data is post-invalidate.
                if (DDRAM_DOUT_READY) begin
                    di_d    = DDRAM_DOUT;
                    line_d  = DDRAM_DOUT;
                    tag_d   = addr_q[SS_WADDR_W-1:0];
                    valid_d = 1'b1;
                    ack_d   = ~ack_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            di_q    <= '0;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            be_q    <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            di_q    <= di_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            be_q    <= be_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            line_q  <= line_d;
        end
    end

    assign ddr_ack        = ack_q;
    assign ddr_di         = di_q;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = addr_q;
    assign DDRAM_RD       = rd_q;
    assign DDRAM_WE       = we_q;
    assign DDRAM_DIN      = din_q;
    assign DDRAM_BE       = be_q;

endmodule

// File: tb/tb_ss_ddr_port.sv
// Scoreboard bench for ss_ddr_port: stimulus pushes expected responses,
// a monitor pops and compares on every ack toggle.
module tb_ss_ddr_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        ddr_req;
    logic        ddr_ack;
    logic [18:0] ddr_addr;
    logic        ddr_we;
    logic [7:0]  ddr_be;
    logic [63:0] ddr_do;
    logic [63:0] ddr_di;
    logic        cache_inv;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic        DDRAM_RD;
    logic        DDRAM_WE;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;

    always #5 clk = ~clk;

    ss_ddr_port #(.ADDR_HI(10'h380)) dut (
        .clk              (clk),
        .reset            (reset),
        .ddr_req          (ddr_req),
        .ddr_ack          (ddr_ack),
        .ddr_addr         (ddr_addr),
        .ddr_we           (ddr_we),
        .ddr_be           (ddr_be),
        .ddr_do           (ddr_do),
        .ddr_di           (ddr_di),
        .cache_inv        (cache_inv),
        .DDRAM_BUSY       (DDRAM_BUSY),
        .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
        .DDRAM_ADDR       (DDRAM_ADDR),
        .DDRAM_RD         (DDRAM_RD),
        .DDRAM_WE         (DDRAM_WE),
        .DDRAM_DIN        (DDRAM_DIN),
        .DDRAM_BE         (DDRAM_BE),
        .DDRAM_DOUT       (DDRAM_DOUT),
        .DDRAM_DOUT_READY (DDRAM_DOUT_READY)
    );

    typedef struct {
        logic [63:0] di;
        int          lat;
        int          rd;
        int          we;
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    function automatic exp_t mk(input logic [63:0] di, input int lat, input int rd, input int we,
                                input logic [28:0] addr, input logic [63:0] din, input logic [7:0] be);
        exp_t e;
        e.di = di; e.lat = lat; e.rd = rd; e.we = we; e.addr = addr; e.din = din; e.be = be;
        return e;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic        last_req, last_ack;
        int          cyc, req_cyc, rd_cnt, we_cnt;
        logic [28:0] cmd_addr;
        logic [63:0] cmd_din;
        logic [7:0]  cmd_be;
        exp_t        e;
        last_req = 1'b0; last_ack = 1'b0;
        cyc = 0; req_cyc = 0; rd_cnt = 0; we_cnt = 0;
        cmd_addr = '0; cmd_din = '0; cmd_be = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (reset) begin
                last_req = ddr_req;
                last_ack = ddr_ack;
                rd_cnt = 0;
                we_cnt = 0;
            end else begin
                if (ddr_req !== last_req) begin
                    last_req = ddr_req;
                    req_cyc  = cyc;
                    rd_cnt   = 0;
                    we_cnt   = 0;
                end
                if (DDRAM_RD) begin
                    rd_cnt++;
                    cmd_addr = DDRAM_ADDR;
                end
                if (DDRAM_WE) begin
                    we_cnt++;
                    cmd_addr = DDRAM_ADDR;
                    cmd_din  = DDRAM_DIN;
                    cmd_be   = DDRAM_BE;
                end
                if (ddr_ack !== last_ack) begin
                    last_ack = ddr_ack;
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack actual=%b expected=no toggle", ddr_ack);
                    end else begin
                        e = sbq.pop_front();
                        chk("ddr_di", ddr_di, e.di);
                        chk("latency", 64'(cyc - req_cyc + 1), 64'(e.lat));
                        chk("rd_cycles", 64'(rd_cnt), 64'(e.rd));
                        chk("we_cycles", 64'(we_cnt), 64'(e.we));
                        if (e.rd > 0 || e.we > 0) chk("ddram_addr", 64'(cmd_addr), 64'(e.addr));
                        if (e.we > 0) begin
                            chk("ddram_din", cmd_din, e.din);
                            chk("ddram_be", 64'(cmd_be), 64'(e.be));
                        end
                    end
                end
            end
        end
    end

    task automatic wait_ack();
        int n;
        n = 0;
        while (ddr_ack !== ddr_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (ddr_ack !== ddr_req) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=%b expected=%b", ddr_ack, ddr_req);
        end
        @(negedge clk);
    endtask

    // Drives one request plus the DDR side: nbusy busy cycles, then (reads) a
    // DOUT_READY pulse rlat cycles later. On hits that pulse lands in IDLE.
    task automatic issue(input logic we, input logic [18:0] a, input logic [7:0] be,
                         input logic [63:0] d, input int nbusy, input int rlat,
                         input logic [63:0] rdata, input logic inv, input exp_t e);
        sbq.push_back(e);
        @(negedge clk);
        ddr_we     = we;
        ddr_addr   = a;
        ddr_be     = be;
        ddr_do     = d;
        DDRAM_BUSY = (nbusy > 0);
        cache_inv  = inv;
        ddr_req    = ~ddr_req;
        repeat (nbusy + 1) begin
            @(negedge clk);
            cache_inv = 1'b0;
        end
        DDRAM_BUSY = 1'b0;
        if (!we) begin
            repeat (rlat) @(negedge clk);
            DDRAM_DOUT       = rdata;
            DDRAM_DOUT_READY = 1'b1;
            @(negedge clk);
            DDRAM_DOUT_READY = 1'b0;
        end
        wait_ack();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ddr_req = 1'b0; ddr_addr = '0; ddr_we = 1'b0; ddr_be = '0; ddr_do = '0;
        cache_inv = 1'b0; DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(ddr_ack), 64'd0);
        chk("rst_di", ddr_di, 64'd0);
        chk("rst_rd", 64'(DDRAM_RD), 64'd0);
        chk("rst_we", 64'(DDRAM_WE), 64'd0);
        chk("rst_addr", 64'(DDRAM_ADDR), 64'd0);
        chk("rst_din", DDRAM_DIN, 64'd0);
        chk("rst_be", 64'(DDRAM_BE), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Write, no busy
        issue(1'b1, 19'h00001, 8'hFF, 64'h0123456789ABCDEF, 0, 0, 64'h0, 1'b0,
              mk(64'h0, 2, 0, 1, 29'h1C000001, 64'h0123456789ABCDEF, 8'hFF));
        // Read miss, 3 busy cycles, data 4 cycles after acceptance
        issue(1'b0, 19'h00001, 8'h00, 64'h0, 3, 4, 64'hCAFE, 1'b0,
              mk(64'hCAFE, 9, 4, 0, 29'h1C000001, 64'h0, 8'h00));
        // Read hit; the stray DOUT_READY arrives in IDLE and is ignored
        issue(1'b0, 19'h00001, 8'h00, 64'h0, 0, 1, 64'hBAD0BAD0BAD0BAD0, 1'b0,
              mk(64'hCAFE, 1, 0, 0, 29'h0, 64'h0, 8'h00));
        // Partial write-through, one busy cycle
        issue(1'b1, 19'h00001, 8'h01, 64'h55, 1, 0, 64'h0, 1'b0,
              mk(64'hCAFE, 3, 0, 2, 29'h1C000001, 64'h55, 8'h01));
        issue(1'b0, 19'h00001, 8'h00, 64'h0, 0, 1, 64'hBAD0BAD0BAD0BAD0, 1'b0,
              mk(64'hCA55, 1, 0, 0, 29'h0, 64'h0, 8'h00));
        // Invalidate coincident with a would-be hit
        issue(1'b0, 19'h00001, 8'h00, 64'h0, 0, 2, 64'h1111, 1'b1,
              mk(64'h1111, 4, 1, 0, 29'h1C000001, 64'h0, 8'h00));
        // Top-of-window address, replaces the cached tag
        issue(1'b0, 19'h7FFFF, 8'h00, 64'h0, 0, 1, 64'hDEADBEEF00000001, 1'b0,
              mk(64'hDEADBEEF00000001, 3, 1, 0, 29'h1C07FFFF, 64'h0, 8'h00));
        issue(1'b0, 19'h00001, 8'h00, 64'h0, 0, 1, 64'h2222, 1'b0,
              mk(64'h2222, 3, 1, 0, 29'h1C000001, 64'h0, 8'h00));

        // Reset while in RDWAIT, then a stray DOUT_READY
        @(negedge clk);
        ddr_we = 1'b0; ddr_addr = 19'h00003; DDRAM_BUSY = 1'b0;
        ddr_req = ~ddr_req;
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        ddr_req = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        DDRAM_DOUT = 64'hABCD;
        DDRAM_DOUT_READY = 1'b1;
        @(negedge clk);
        DDRAM_DOUT_READY = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_ack", 64'(ddr_ack), 64'd0);
        chk("midrst_di", ddr_di, 64'd0);
        chk("midrst_rd", 64'(DDRAM_RD), 64'd0);
        chk("midrst_addr", 64'(DDRAM_ADDR), 64'd0);

        // Cache must be invalid after reset: previously cached address misses
        issue(1'b0, 19'h00001, 8'h00, 64'h0, 0, 1, 64'h3333, 1'b0,
              mk(64'h3333, 3, 1, 0, 29'h1C000001, 64'h0, 8'h00));

        repeat (3) @(negedge clk);
        chk("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
